// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop process one
// bit per clock, with a registered START/BUSY/DONE handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVERFLOW
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_s;
  logic             cout_s;

  // Next-state and datapath decode; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    bit_s   = fa_sum(a_q[0], b_q[0], c_q);
    cout_s  = fa_carry(a_q[0], b_q[0], c_q);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          c_d     = CIN;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        c_d    = cout_s;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        psum_d = {bit_s, psum_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // On the last bit a_q[0]/b_q[0] hold the captured operand MSBs.
        if (cnt_q == LAST_BIT) begin
          state_d = S_FIN;
          sum_d   = {bit_s, psum_q[WIDTH-1:1]};
          carry_d = cout_s;
          ovf_d   = (a_q[0] == b_q[0]) && (bit_s != a_q[0]);
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SUM      = sum_q;
  assign CARRY    = carry_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table vectors, multi-cycle corner
// sequences, random operands against an arithmetic model, WIDTH=2 sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, carry8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, carry2, ovf2;
  logic [1:0] a2, b2, sum2;

  int checks;
  int errors;

  logic [7:0] prev_sum;
  logic       prev_c, prev_o;

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY(carry8), .OVERFLOW(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .A(a2), .B(b2), .CIN(cin2),
    .BUSY(busy2), .DONE(done2), .SUM(sum2), .CARRY(carry2), .OVERFLOW(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    bit         scr;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow as signed result out of range.
  function automatic void model(input int w, input longint a, input longint b,
                                input longint ci, output longint s,
                                output bit c, output bit o);
    longint full, u, sa, sb, t;
    full = longint'(1) << w;
    u  = a + b + ci;
    s  = u % full;
    c  = (u >= full);
    sa = (a >= full / 2) ? a - full : a;
    sb = (b >= full / 2) ? b - full : b;
    t  = sa + sb + ci;
    o  = (t >= full / 2) || (t < -(full / 2));
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input bit scr, input logic [7:0] es, input logic ec,
                        input logic eo, input string nm);
    int k;
    bit run_ok;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    run_ok = 1'b1;
    while (!done8 && k < 12) begin
      if (busy8 !== 1'b1 || sum8 !== prev_sum || carry8 !== prev_c || ovf8 !== prev_o)
        run_ok = 1'b0;
      if (scr) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    chk({nm, " run"}, 32'(run_ok), 32'd1);
    chk({nm, " latency"}, 32'(k), 32'd8);
    chk({nm, " busy_at_done"}, 32'(busy8), 32'd0);
    chk({nm, " sum"}, 32'(sum8), 32'(es));
    chk({nm, " carry"}, 32'(carry8), 32'(ec));
    chk({nm, " ovf"}, 32'(ovf8), 32'(eo));
    prev_sum = es; prev_c = ec; prev_o = eo;
    @(negedge clk);
    chk({nm, " done_width"}, 32'({done8, busy8}), 32'd0);
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    int k;
    longint s;
    bit c, o;
    model(2, longint'(a), longint'(b), longint'(ci), s, c, o);
    @(negedge clk);
    a2 = a; b2 = b; cin2 = ci; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("w2 latency", 32'(k), 32'd2);
    chk("w2 sum", 32'({carry2, sum2}), 32'({c, s[1:0]}));
    chk("w2 ovf", 32'(ovf2), 32'(o));
  endtask

  vec_t tbl[5];

  initial begin
    longint s;
    bit c, o;
    int donecnt;
    logic [7:0] cur_s;
    logic cur_c, cur_o;

    checks = 0; errors = 0;
    prev_sum = 8'h00; prev_c = 1'b0; prev_o = 1'b0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset outputs", 32'({busy8, done8, sum8, carry8, ovf8}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op8(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].scr, tbl[i].es, tbl[i].ec,
             tbl[i].eo, $sformatf("vec%0d", i));

    // START held high: captures at edges 0, 10, 20; DONE after edges 8, 18, 28.
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    model(8, longint'(a8), longint'(b8), longint'(cin8), s, c, o);
    cur_s = s[7:0]; cur_c = c; cur_o = o;
    start8 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk($sformatf("held done k=%0d", k), 32'(done8), 32'((k % 10) == 8));
      chk($sformatf("held busy k=%0d", k), 32'(busy8), 32'((k % 10) < 8));
      if ((k % 10) == 8) begin
        prev_sum = cur_s; prev_c = cur_c; prev_o = cur_o;
      end
      chk($sformatf("held result k=%0d", k), 32'({carry8, ovf8, sum8}),
          32'({prev_c, prev_o, prev_sum}));
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if ((k % 10) == 9) begin
        model(8, longint'(a8), longint'(b8), longint'(cin8), s, c, o);
        cur_s = s[7:0]; cur_c = c; cur_o = o;
      end
    end
    start8 = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN aborts with no DONE.
    do_op8(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset outputs", 32'({busy8, done8, sum8, carry8, ovf8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = 8'h00; prev_c = 1'b0; prev_o = 1'b0;
    donecnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) donecnt++;
    end
    chk("aborted op silent", 32'(donecnt), 32'd0);
    do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "after_reset");

    // Random operands, scrambled inputs during RUN.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model(8, longint'(ra), longint'(rb), longint'(rc), s, c, o);
      do_op8(ra, rb, rc, 1'b1, s[7:0], c, o, $sformatf("rand%0d", i));
    end

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int ci = 0; ci < 2; ci++)
          do_op2(2'(a), 2'(b), 1'(ci));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
